seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_pkg.sv | 25 ++
 rtl/seq_alu_mul.sv | 58 +++++
 rtl/seq_alu.sv | 176 +++++++++++++++++
 tb/tb_seq_alu.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared opcode and FSM state types for the sequential ALU.
package seq_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLL = 3'd5,
        OP_SRA = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_shift(input op_e op);
        return (op == OP_SLL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// seq_alu_mul: iterative shift-add unsigned multiplier, one partial product
// per cycle for WIDTH cycles after start. Only built when SEQ_ALU_MUL_EN is
// defined. done is high during the last iteration cycle and p carries the
// final product in that same cycle, so the parent can latch it on that edge.
module seq_alu_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int SHW = $clog2(WIDTH);

    logic               busy;
    logic [SHW-1:0]     cnt;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH:0]     sum;

    // Next {hi,lo}: add multiplicand when the current multiplier bit is set, then shift right.
    always_comb begin
        sum = {1'b0, hi} + {1'b0, (lo[0] ? mcand : '0)};
        p   = {sum, lo[WIDTH-1:1]};
    end

    assign done = busy && (cnt == '0);

    // Down-counter sequencing of the WIDTH iterations.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= SHW'(WIDTH - 1);
            hi    <= '0;
            lo    <= b;
            mcand <= a;
        end else if (busy) begin
            {hi, lo} <= p;
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - SHW'(1);
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with valid/ready handshake on both sides.
// Optional multiplier enabled by defining SEQ_ALU_MUL_EN; without it op=7
// returns zero in one cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a request (in_ready=1 unless rst)
// ST_BUSY | multi-cycle op running (shift: 1 bit/cycle, mul: WIDTH cycles)
// ST_DONE | result valid, held until out_ready
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [SHW-1:0]    shamt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  s,
    output logic              z,
    output logic              o,
    output logic              c
);

    state_e             state;
    op_e                op_q;
    logic [WIDTH-1:0]   work;
    logic [SHW-1:0]     cnt;

    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic [WIDTH-1:0]   fast_s;
    logic               fast_c;
    logic               fast_o;
    logic               is_multi;
    logic [WIDTH-1:0]   step_s;
    logic               step_c;

    assign in_ready  = (state == ST_IDLE) && !rst;
    assign out_valid = (state == ST_DONE);

`ifdef SEQ_ALU_MUL_EN
    logic                 mul_start;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_p;

    assign mul_start = in_valid && in_ready && (op_e'(op) == OP_MUL);

    seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (a),
        .b     (b),
        .done  (mul_done),
        .p     (mul_p)
    );
`endif

    // Single-cycle results straight from the request operands.
    always_comb begin
        add_full = {1'b0, a} + {1'b0, b};
        sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        fast_s   = '0;
        fast_c   = 1'b0;
        fast_o   = 1'b0;
        case (op_e'(op))
            OP_ADD: begin
                fast_s = add_full[WIDTH-1:0];
                fast_c = add_full[WIDTH];
                fast_o = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                fast_s = sub_full[WIDTH-1:0];
                fast_c = sub_full[WIDTH];
                fast_o = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:          fast_s = a & b;
            OP_OR:           fast_s = a | b;
            OP_XOR:          fast_s = a ^ b;
            OP_SLL, OP_SRA:  fast_s = a;
            default:         fast_s = '0;
        endcase
    end

    // Requests that need BUSY cycles: nonzero shifts, and MUL when built in.
    always_comb begin
        is_multi = is_shift(op_e'(op)) && (shamt != '0);
`ifdef SEQ_ALU_MUL_EN
        if (op_e'(op) == OP_MUL) begin
            is_multi = 1'b1;
        end
`endif
    end

    // One-bit shift step on the working register; step_c is the bit falling off.
    always_comb begin
        if (op_q == OP_SRA) begin
            step_s = {work[WIDTH-1], work[WIDTH-1:1]};
            step_c = work[0];
        end else begin
            step_s = {work[WIDTH-2:0], 1'b0};
            step_c = work[WIDTH-1];
        end
    end

    // Control FSM with registered result and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            op_q  <= OP_ADD;
            work  <= '0;
            cnt   <= '0;
            s     <= '0;
            z     <= 1'b0;
            o     <= 1'b0;
            c     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q <= op_e'(op);
                        work <= a;
                        cnt  <= shamt - SHW'(1);
                        if (is_multi) begin
                            state <= ST_BUSY;
                        end else begin
                            s     <= fast_s;
                            z     <= (fast_s == '0);
                            o     <= fast_o;
                            c     <= fast_c;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    if (is_shift(op_q)) begin
                        work <= step_s;
                        if (cnt == '0) begin
                            s     <= step_s;
                            z     <= (step_s == '0);
                            o     <= 1'b0;
                            c     <= step_c;
                            state <= ST_DONE;
                        end else begin
                            cnt <= cnt - SHW'(1);
                        end
                    end
`ifdef SEQ_ALU_MUL_EN
                    else if (mul_done) begin
                        s     <= mul_p[WIDTH-1:0];
                        z     <= (mul_p[WIDTH-1:0] == '0);
                        o     <= |mul_p[2*WIDTH-1:WIDTH];
                        c     <= 1'b0;
                        state <= ST_DONE;
                    end
`endif
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors for seq_alu at WIDTH=8 with hand-computed results.
// MUL expectations follow SEQ_ALU_MUL_EN.
module tb_seq_alu;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                           XOR_ = 3'd4, SLL = 3'd5, SRA = 3'd6, MUL = 3'd7;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] shamt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] s;
    logic       z;
    logic       o;
    logic       c;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .z         (z),
        .o         (o),
        .c         (c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, measure latency to out_valid, check result, then handshake.
    task automatic do_op(input string tag, input logic [2:0] op_i, input logic [7:0] a_i,
                         input logic [7:0] b_i, input logic [2:0] sh_i, input logic [7:0] es,
                         input logic ez, input logic eo, input logic ec, input int elat);
        int lat;
        @(negedge clk);
        check({tag, "_rdy"}, in_ready, 1);
        in_valid = 1'b1;
        op       = op_i;
        a        = a_i;
        b        = b_i;
        shamt    = sh_i;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (lat <= 40) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        check({tag, "_lat"}, lat, elat);
        check({tag, "_s"}, s, es);
        check({tag, "_zoc"}, {z, o, c}, {ez, eo, ec});
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_ready_after"}, in_ready, 1);
    endtask

    initial begin
        int lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        a         = '0;
        b         = '0;
        shamt     = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", {s, z, o, c}, 0);
        check("rst_release_ready", in_ready, 1);

        do_op("add_ovf",  ADD,  8'h7F, 8'h01, 3'd0, 8'h80, 1'b0, 1'b1, 1'b0, 1);
        do_op("add_cry",  ADD,  8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1);
        do_op("sub_eq",   SUB,  8'h05, 8'h05, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1);
        do_op("sub_brw",  SUB,  8'h00, 8'h01, 3'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 1);
        do_op("sub_ovf",  SUB,  8'h80, 8'h01, 3'd0, 8'h7F, 1'b0, 1'b1, 1'b1, 1);
        do_op("and",      AND_, 8'hF0, 8'h3C, 3'd0, 8'h30, 1'b0, 1'b0, 1'b0, 1);
        do_op("or",       OR_,  8'hF0, 8'h0F, 3'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 1);
        do_op("xor",      XOR_, 8'hAA, 8'hAA, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1);
        do_op("sll3",     SLL,  8'h81, 8'h00, 3'd3, 8'h08, 1'b0, 1'b0, 1'b0, 4);
        do_op("sra1",     SRA,  8'h81, 8'h00, 3'd1, 8'hC0, 1'b0, 1'b0, 1'b1, 2);
        do_op("sll0",     SLL,  8'h5A, 8'h00, 3'd0, 8'h5A, 1'b0, 1'b0, 1'b0, 1);
        do_op("sll2",     SLL,  8'h40, 8'h00, 3'd2, 8'h00, 1'b1, 1'b0, 1'b1, 3);
        do_op("sra7",     SRA,  8'h80, 8'h00, 3'd7, 8'hFF, 1'b0, 1'b0, 1'b0, 8);
`ifdef SEQ_ALU_MUL_EN
        do_op("mul_hi",   MUL,  8'h10, 8'h10, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 9);
        do_op("mul_lo",   MUL,  8'h0F, 8'h03, 3'd0, 8'h2D, 1'b0, 1'b0, 1'b0, 9);
`else
        do_op("mul_off",  MUL,  8'h0F, 8'h03, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1);
`endif

        // Back-pressure: result held, no ready, new requests ignored.
        @(negedge clk);
        in_valid = 1'b1;
        op       = ADD;
        a        = 8'h03;
        b        = 8'h04;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("stall_valid", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            op       = SUB;
            a        = 8'h09;
            b        = 8'h01;
            @(negedge clk);
            check("stall_hold_valid", out_valid, 1);
            check("stall_hold_s", s, 8'h07);
            check("stall_hold_flags", {z, o, c}, 3'b000);
            check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("stall_ready_after", in_ready, 1);
        check("stall_valid_after", out_valid, 0);
        @(negedge clk);
        check("stall_ignored", {out_valid, s}, {1'b0, 8'h07});

        // Reset in the 3rd BUSY cycle of SLL by 7.
        @(negedge clk);
        in_valid = 1'b1;
        op       = SLL;
        a        = 8'h01;
        shamt    = 3'd7;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort_busy", out_valid, 0);
        rst = 1'b1;
        #1 check("abort_rst_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ready_after", in_ready, 1);
        check("abort_cleared", {s, z, o, c}, 0);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) lat++;
        end
        check("abort_no_result", lat, 0);
        do_op("add_after", ADD, 8'h12, 8'h34, 3'd0, 8'h46, 1'b0, 1'b0, 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
